// File: rtl/pll_reset_cen_gen_pkg.sv
// Shared types and 48 MHz defaults for the PLL reset sequencer and clock-enable generator.
package pll_reset_cen_gen_pkg;

   typedef enum logic [1:0] {
      StWaitLock = 2'd0,
      StHold     = 2'd1,
      StRun      = 2'd2
   } state_e;

   // 48 MHz in: 6 MHz pixel, 3 MHz CPU, 48 * 179 / 4800 ~= 1.79 MHz sound.
   localparam int unsigned DefHoldCycles = 1024;
   localparam int unsigned DefDivPix     = 8;
   localparam int unsigned DefDivCpu     = 16;
   localparam int unsigned DefFracNum    = 179;
   localparam int unsigned DefFracDen    = 4800;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < {32'd0, value}) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/pll_reset_cen_gen_sync2.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module pll_reset_cen_gen_sync2 #(
   parameter logic ResetValue = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= ResetValue;
         q_o    <= ResetValue;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/pll_reset_cen_gen.sv
// Lock-qualified core reset sequencer plus pixel, CPU and fractional sound clock enables.
module pll_reset_cen_gen
   import pll_reset_cen_gen_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = DefHoldCycles,
   parameter int unsigned DIV_PIX     = DefDivPix,
   parameter int unsigned DIV_CPU     = DefDivCpu,
   parameter int unsigned FRAC_NUM    = DefFracNum,
   parameter int unsigned FRAC_DEN    = DefFracDen
) (
   input  logic clk,
   input  logic rst,
   input  logic pll_locked,
   input  logic soft_reset,
   output logic core_reset,
   output logic running,
   output logic cen_pix,
   output logic cen_cpu,
   output logic cen_snd
);

   localparam int unsigned HoldW = clog2(HOLD_CYCLES) + 1;
   localparam int unsigned PixW  = clog2(DIV_PIX);
   localparam int unsigned CpuW  = clog2(DIV_CPU);
   localparam int unsigned AccW  = clog2(FRAC_DEN) + 1;

   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
   localparam logic [PixW-1:0]  PixLast  = PixW'(DIV_PIX - 1);
   localparam logic [CpuW-1:0]  CpuLast  = CpuW'(DIV_CPU - 1);
   localparam logic [AccW-1:0]  FracNumW = AccW'(FRAC_NUM);
   localparam logic [AccW-1:0]  FracDenW = AccW'(FRAC_DEN);

   logic lock_s;
   logic srst_s;

   state_e           state_q, state_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic [PixW-1:0]  pix_q, pix_d;
   logic [CpuW-1:0]  cpu_q, cpu_d;
   logic [AccW-1:0]  acc_q, acc_d;
   logic [AccW-1:0]  acc_sum;
   logic             keep_run;
   logic             pix_hit, cpu_hit, snd_hit;

   pll_reset_cen_gen_sync2 #(
      .ResetValue(1'b0)
   ) u_sync_lock (
      .clk (clk),
      .rst (rst),
      .d_i (pll_locked),
      .q_o (lock_s)
   );

   pll_reset_cen_gen_sync2 #(
      .ResetValue(1'b0)
   ) u_sync_srst (
      .clk (clk),
      .rst (rst),
      .d_i (soft_reset),
      .q_o (srst_s)
   );

   // Loss of lock always wins over a soft reset request.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         StWaitLock: begin
            hold_d = '0;
            if (lock_s && !srst_s) begin
               state_d = StHold;
            end
         end
         StHold: begin
            if (!lock_s) begin
               state_d = StWaitLock;
               hold_d  = '0;
            end else if (srst_s) begin
               hold_d = '0;
            end else if (hold_q == HoldLast) begin
               state_d = StRun;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         StRun: begin
            if (!lock_s) begin
               state_d = StWaitLock;
            end else if (srst_s) begin
               state_d = StHold;
               hold_d  = '0;
            end
         end
         default: begin
            state_d = StWaitLock;
            hold_d  = '0;
         end
      endcase
   end

   // Dividers only advance while staying in RUN, so the entry edge loads zero phase and
   // the exit edge kills the enables together with core_reset.
   assign keep_run = (state_q == StRun) && (state_d == StRun);
   assign acc_sum  = acc_q + FracNumW;

   always_comb begin
      pix_d   = '0;
      cpu_d   = '0;
      acc_d   = '0;
      pix_hit = 1'b0;
      cpu_hit = 1'b0;
      snd_hit = 1'b0;
      if (keep_run) begin
         pix_hit = (pix_q == PixLast);
         cpu_hit = (cpu_q == CpuLast);
         pix_d   = pix_hit ? '0 : pix_q + 1'b1;
         cpu_d   = cpu_hit ? '0 : cpu_q + 1'b1;
         if (acc_sum >= FracDenW) begin
            acc_d   = acc_sum - FracDenW;
            snd_hit = 1'b1;
         end else begin
            acc_d = acc_sum;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StWaitLock;
         hold_q     <= '0;
         pix_q      <= '0;
         cpu_q      <= '0;
         acc_q      <= '0;
         core_reset <= 1'b1;
         running    <= 1'b0;
         cen_pix    <= 1'b0;
         cen_cpu    <= 1'b0;
         cen_snd    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         pix_q      <= pix_d;
         cpu_q      <= cpu_d;
         acc_q      <= acc_d;
         core_reset <= (state_d != StRun);
         running    <= (state_d == StRun);
         cen_pix    <= pix_hit;
         cen_cpu    <= cpu_hit;
         cen_snd    <= snd_hit;
      end
   end

endmodule

// File: tb/tb_pll_reset_cen_gen.sv
// Directed bench for pll_reset_cen_gen with a 16-clock hold window.
module tb_pll_reset_cen_gen;
   import pll_reset_cen_gen_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic pll_locked;
   logic soft_reset;
   logic core_reset;
   logic running;
   logic cen_pix;
   logic cen_cpu;
   logic cen_snd;

   int tests = 0;
   int failures = 0;

   pll_reset_cen_gen #(
      .HOLD_CYCLES(16),
      .DIV_PIX    (8),
      .DIV_CPU    (16),
      .FRAC_NUM   (179),
      .FRAC_DEN   (4800)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .soft_reset (soft_reset),
      .core_reset (core_reset),
      .running    (running),
      .cen_pix    (cen_pix),
      .cen_cpu    (cen_cpu),
      .cen_snd    (cen_snd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Counts edges until core_reset reaches val (bounded), noting any enable seen meanwhile.
   task automatic edges_until(input logic val, output int n, output int cens_seen);
      n = 0;
      cens_seen = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (cen_pix || cen_cpu || cen_snd) cens_seen++;
      end while (core_reset != val && n < 200);
   endtask

   initial begin
      int n;
      int seen;
      int bad;
      int pix_n, cpu_n, snd_n, first_pix, first_cpu, orphan, adj;
      logic prev_snd;
      logic [2:0] seq;

      rst = 1'b1;
      pll_locked = 1'b0;
      soft_reset = 1'b0;

      // Power-up
      @(posedge clk);
      #1;
      check("reset_core_reset", core_reset, 1);
      check("reset_running", running, 0);
      check("reset_cens", {cen_pix, cen_cpu, cen_snd}, 0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (core_reset != 1'b1 || running || cen_pix || cen_cpu || cen_snd) bad++;
      end
      check("no_lock_idle", bad, 0);

      // Lock release: 2 sync + 1 decision + 16 hold edges
      pll_locked = 1'b1;
      edges_until(1'b0, n, seen);
      check("lock_release_edges", n, 19);
      check("lock_release_running", running, 1);
      check("hold_cens_quiet", seen, 0);

      // Enable cadence over 4800 RUN clocks
      pix_n = 0; cpu_n = 0; snd_n = 0;
      first_pix = 0; first_cpu = 0; orphan = 0; adj = 0;
      prev_snd = 1'b0;
      for (int i = 1; i <= 4800; i++) begin
         @(posedge clk);
         #1;
         if (cen_pix) begin
            pix_n++;
            if (first_pix == 0) first_pix = i;
         end
         if (cen_cpu) begin
            cpu_n++;
            if (first_cpu == 0) first_cpu = i;
            if (!cen_pix) orphan++;
         end
         if (cen_snd) begin
            snd_n++;
            if (prev_snd) adj++;
         end
         prev_snd = cen_snd;
      end
      check("first_cen_pix", first_pix, 8);
      check("first_cen_cpu", first_cpu, 16);
      check("pix_count", pix_n, 600);
      check("cpu_count", cpu_n, 300);
      check("snd_count", snd_n, 179);
      check("cpu_without_pix", orphan, 0);
      check("snd_adjacent", adj, 0);

      // Soft reset: 3-clock pulse
      soft_reset = 1'b1;
      seq = 3'b000;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         seq = {seq[1:0], core_reset};
      end
      soft_reset = 1'b0;
      check("srst_assert_seq", seq, 3'b001);
      check("srst_cens_off", {cen_pix, cen_cpu, cen_snd}, 0);
      edges_until(1'b0, n, seen);
      check("srst_recover_edges", n, 18);
      check("srst_cens_quiet", seen, 0);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!cen_pix && n < 100);
      check("srst_first_pix", n, 8);

      // Lock loss with soft reset also asserted
      pll_locked = 1'b0;
      soft_reset = 1'b1;
      seq = 3'b000;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         seq = {seq[1:0], core_reset};
      end
      check("lockloss_assert_seq", seq, 3'b001);
      check("lockloss_state", int'(dut.state_q), int'(StWaitLock));
      check("lockloss_running", running, 0);
      soft_reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("lockloss_state_stays", int'(dut.state_q), int'(StWaitLock));
      check("lockloss_core_reset", core_reset, 1);
      pll_locked = 1'b1;
      edges_until(1'b0, n, seen);
      check("relock_release_edges", n, 19);
      check("relock_cens_quiet", seen, 0);

      // Async reset between edges
      repeat (8) @(posedge clk);
      #1;
      check("pre_rst_cen_pix", cen_pix, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_core_reset", core_reset, 1);
      check("async_running", running, 0);
      check("async_cens", {cen_pix, cen_cpu, cen_snd}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
